// File: rtl/snoop_pkg.sv
// snoop_pkg: shared definitions for the snooping-bus cache responder.
//   - MSI line state encodings
//   - bus message type codes and probe kinds
//   - bus field layout helpers: {kind, type, addr, data}, from MSB to LSB
//   - responder FSM state type
package snoop_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_M = 2'b10
  } msi_t;

  localparam int unsigned MSG_W  = 2;
  localparam int unsigned KIND_W = 2;

  localparam logic [MSG_W-1:0] MSG_DATA  = 2'b00;
  localparam logic [MSG_W-1:0] MSG_WB    = 2'b01;
  localparam logic [MSG_W-1:0] MSG_INV   = 2'b10;
  localparam logic [MSG_W-1:0] MSG_PROBE = 2'b11;

  localparam logic [KIND_W-1:0] KIND_RD_MISS = 2'b00;
  localparam logic [KIND_W-1:0] KIND_WR_MISS = 2'b01;

  localparam int unsigned BUS_DATA_LSB = 0;

  function automatic int unsigned bus_addr_lsb(input int unsigned data_w);
    return BUS_DATA_LSB + data_w;
  endfunction

  function automatic int unsigned bus_type_lsb(input int unsigned addr_w,
                                               input int unsigned data_w);
    return bus_addr_lsb(data_w) + addr_w;
  endfunction

  function automatic int unsigned bus_kind_lsb(input int unsigned addr_w,
                                               input int unsigned data_w);
    return bus_type_lsb(addr_w, data_w) + MSG_W;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RESPOND,
    UPDATE,
    HOLD
  } fsm_t;

endpackage

// File: rtl/snoop_tag_array.sv
// snoop_tag_array: LINES-entry direct-mapped store of {tag, data, MSI state}.
//   clk_i, rst_ni          clock, async active-low clear (all lines I, tag/data 0)
//   rd_idx_i -> rd_*_o     combinational read port
//   we_i, wr_idx_i, wr_*_i synchronous write port
module snoop_tag_array
  import snoop_pkg::*;
#(
  parameter int unsigned LINES  = 4,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned TAG_W  = 1,
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  output msi_t              rd_state_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  msi_t              wr_state_i
);

  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [DATA_W-1:0] data_q  [LINES];
  msi_t              state_q [LINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
        state_q[i] <= ST_I;
      end
    end else if (we_i) begin
      tag_q[wr_idx_i]   <= wr_tag_i;
      data_q[wr_idx_i]  <= wr_data_i;
      state_q[wr_idx_i] <= wr_state_i;
    end
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];
  assign rd_state_o = state_q[rd_idx_i];

endmodule

// File: rtl/snoop_responder.sv
// snoop_responder: cache-side end of the snooping bus protocol.
//   clock, clear       rising-edge clock, async active-low reset
//   snoop_en, bus      listen window (rising edge starts one snoop) and bus message
//   shared            addressed block held in S or M
//   bus_out, wb_valid  abort/write-back message offered to the sequencer
//   loc_*              local install/update port (ready/valid)
//   snoop_done         one-cycle pulse when the snoop's state update is applied
// Optional: SNOOP_STATS_EN adds saturating hit_cnt / wb_cnt outputs.
module snoop_responder
  import snoop_pkg::*;
#(
  parameter int unsigned LINES  = 4,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 3
) (
  input  logic                                  clock,
  input  logic                                  clear,
  input  logic                                  snoop_en,
  input  logic [KIND_W+MSG_W+ADDR_W+DATA_W-1:0] bus,
  output logic                                  shared,
  output logic [KIND_W+MSG_W+ADDR_W+DATA_W-1:0] bus_out,
  output logic                                  wb_valid,
  input  logic                                  loc_valid,
  output logic                                  loc_ready,
  input  logic [ADDR_W-1:0]                     loc_addr,
  input  logic [DATA_W-1:0]                     loc_data,
  input  logic [1:0]                            loc_state,
  output logic                                  snoop_done
`ifdef SNOOP_STATS_EN
  ,
  output logic [7:0]                            hit_cnt,
  output logic [7:0]                            wb_cnt
`endif
);

  localparam int unsigned BUS_W  = KIND_W + MSG_W + ADDR_W + DATA_W;
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W;
  localparam int unsigned A_LSB  = bus_addr_lsb(DATA_W);
  localparam int unsigned T_LSB  = bus_type_lsb(ADDR_W, DATA_W);
  localparam int unsigned K_LSB  = bus_kind_lsb(ADDR_W, DATA_W);

  fsm_t              state_q;
  logic              snoop_en_q;
  logic [KIND_W-1:0] kind_q;
  logic [MSG_W-1:0]  type_q;
  logic [ADDR_W-1:0] addr_q;
  logic              hit_q;
  msi_t              lstate_q;
  logic [DATA_W-1:0] ldata_q;
  logic              shared_q;
  logic [BUS_W-1:0]  bus_out_q;
  logic              wb_valid_q;
  logic              done_q;

  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  msi_t              rd_state;
  logic              we;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;
  msi_t              wr_state;

  logic snoop_rise;
  logic is_probe, rd_probe, wr_probe, is_inv, kill, targeted, ignored;

  assign snoop_rise = snoop_en & ~snoop_en_q;

  assign is_probe = (type_q == MSG_PROBE);
  assign rd_probe = is_probe && (kind_q == KIND_RD_MISS);
  assign wr_probe = is_probe && (kind_q == KIND_WR_MISS);
  assign is_inv   = (type_q == MSG_INV);
  assign kill     = wr_probe | is_inv;
  assign targeted = rd_probe | kill;
  // Probes of unknown kind behave as if nothing matched.
  assign ignored  = is_probe & ~(rd_probe | wr_probe);

  // Gated with clear so the local port never looks ready while in reset.
  assign loc_ready = clear && (state_q == IDLE) && !snoop_rise;

  snoop_tag_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk_i     (clock),
    .rst_ni    (clear),
    .rd_idx_i  (addr_q[IDX_W-1:0]),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .rd_state_o(rd_state),
    .we_i      (we),
    .wr_idx_i  (wr_idx),
    .wr_tag_i  (wr_tag),
    .wr_data_i (wr_data),
    .wr_state_i(wr_state)
  );

  // Single write port: the snoop update owns it in UPDATE, the local port
  // otherwise (loc_ready is low outside IDLE, so the two never collide).
  always_comb begin
    we       = 1'b0;
    wr_idx   = loc_addr[IDX_W-1:0];
    wr_tag   = loc_addr[ADDR_W-1:IDX_W];
    wr_data  = loc_data;
    wr_state = msi_t'(loc_state);
    if (state_q == UPDATE) begin
      we      = hit_q && targeted;
      wr_idx  = addr_q[IDX_W-1:0];
      wr_tag  = addr_q[ADDR_W-1:IDX_W];
      wr_data = ldata_q;
      if (kill) wr_state = ST_I;
      else      wr_state = (lstate_q == ST_M) ? ST_S : lstate_q;
    end else if (loc_valid && loc_ready) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      snoop_en_q <= 1'b0;
      kind_q     <= '0;
      type_q     <= '0;
      addr_q     <= '0;
      hit_q      <= 1'b0;
      lstate_q   <= ST_I;
      ldata_q    <= '0;
      shared_q   <= 1'b0;
      bus_out_q  <= '0;
      wb_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      snoop_en_q <= snoop_en;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (snoop_rise) begin
            kind_q  <= bus[K_LSB +: KIND_W];
            type_q  <= bus[T_LSB +: MSG_W];
            addr_q  <= bus[A_LSB +: ADDR_W];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q    <= (rd_state != ST_I) && (rd_tag == addr_q[ADDR_W-1:IDX_W]);
          lstate_q <= rd_state;
          ldata_q  <= rd_data;
          state_q  <= RESPOND;
        end
        RESPOND: begin
          shared_q <= hit_q && !ignored;
          if (hit_q && (lstate_q == ST_M) && targeted) begin
            bus_out_q  <= {{KIND_W{1'b0}}, MSG_WB, addr_q, ldata_q};
            wb_valid_q <= 1'b1;
          end else begin
            bus_out_q  <= '0;
            wb_valid_q <= 1'b0;
          end
          state_q <= UPDATE;
        end
        UPDATE: begin
          done_q  <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          // shared stays until the next snoop overwrites it.
          if (!snoop_en) begin
            bus_out_q  <= '0;
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shared     = shared_q;
  assign bus_out    = bus_out_q;
  assign wb_valid   = wb_valid_q;
  assign snoop_done = done_q;

`ifdef SNOOP_STATS_EN
  logic [7:0] hit_cnt_q;
  logic [7:0] wb_cnt_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hit_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else if (state_q == UPDATE) begin
      if (hit_q && (hit_cnt_q != '1))      hit_cnt_q <= hit_cnt_q + 8'd1;
      if (wb_valid_q && (wb_cnt_q != '1))  wb_cnt_q  <= wb_cnt_q + 8'd1;
    end
  end

  assign hit_cnt = hit_cnt_q;
  assign wb_cnt  = wb_cnt_q;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: directed self-checking bench for snoop_responder.
module tb_snoop_responder;

  logic       clock = 1'b0;
  logic       clear;
  logic       snoop_en;
  logic [9:0] bus;
  logic       shared;
  logic [9:0] bus_out;
  logic       wb_valid;
  logic       loc_valid;
  logic       loc_ready;
  logic [2:0] loc_addr;
  logic [2:0] loc_data;
  logic [1:0] loc_state;
  logic       snoop_done;
`ifdef SNOOP_STATS_EN
  logic [7:0] hit_cnt;
  logic [7:0] wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  snoop_responder #(
    .LINES (4),
    .ADDR_W(3),
    .DATA_W(3)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .snoop_en  (snoop_en),
    .bus       (bus),
    .shared    (shared),
    .bus_out   (bus_out),
    .wb_valid  (wb_valid),
    .loc_valid (loc_valid),
    .loc_ready (loc_ready),
    .loc_addr  (loc_addr),
    .loc_data  (loc_data),
    .loc_state (loc_state),
    .snoop_done(snoop_done)
`ifdef SNOOP_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .wb_cnt    (wb_cnt)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic install(input logic [2:0] a, input logic [2:0] d, input logic [1:0] s);
    int n;
    loc_addr  = a;
    loc_data  = d;
    loc_state = s;
    loc_valid = 1'b1;
    #1;
    n = 0;
    while (!loc_ready && n < 20) begin
      tick();
      n++;
    end
    chk("install_ready", {15'd0, loc_ready}, 16'd1);
    tick();
    loc_valid = 1'b0;
  endtask

  // Full snoop with snoop_en held through two extra HOLD cycles.
  task automatic snoop(input string tag, input logic [1:0] kind, input logic [1:0] typ,
                       input logic [2:0] a, input logic exp_sh, input logic exp_wb,
                       input logic [9:0] exp_bus);
    bus      = {kind, typ, a, 3'b000};
    snoop_en = 1'b1;
    tick();  // LOOKUP
    tick();  // RESPOND
    tick();  // outputs valid
    chk({tag, "_shared"}, {15'd0, shared}, {15'd0, exp_sh});
    chk({tag, "_wb"}, {15'd0, wb_valid}, {15'd0, exp_wb});
    chk({tag, "_bus"}, {6'd0, bus_out}, {6'd0, exp_bus});
    chk({tag, "_done0"}, {15'd0, snoop_done}, 16'd0);
    tick();
    chk({tag, "_done1"}, {15'd0, snoop_done}, 16'd1);
    tick();
    chk({tag, "_once"}, {15'd0, snoop_done}, 16'd0);
    chk({tag, "_wbhold"}, {15'd0, wb_valid}, {15'd0, exp_wb});
    snoop_en = 1'b0;
    tick();
    chk({tag, "_wbclr"}, {5'd0, wb_valid, bus_out}, 16'd0);
    chk({tag, "_shkeep"}, {15'd0, shared}, {15'd0, exp_sh});
  endtask

  initial begin
    clear     = 1'b0;
    snoop_en  = 1'b0;
    bus       = '0;
    loc_valid = 1'b0;
    loc_addr  = '0;
    loc_data  = '0;
    loc_state = '0;

    // Reset values
    #12;
    chk("rst_outs", {12'd0, shared, wb_valid, snoop_done, loc_ready}, 16'd0);
    chk("rst_bus", {6'd0, bus_out}, 16'd0);
    clear = 1'b1;
    tick();
    chk("idle_ready", {15'd0, loc_ready}, 16'd1);

    // M line read-miss probe: write-back, downgrade to S
    install(3'b010, 3'b101, 2'b10);
    snoop("rd_m", 2'b00, 2'b11, 3'b010, 1'b1, 1'b1, 10'h055);
    // S line write-miss probe: invalidated, no write-back
    snoop("wr_s", 2'b01, 2'b11, 3'b010, 1'b1, 1'b0, 10'h000);
    snoop("wr_again", 2'b01, 2'b11, 3'b010, 1'b0, 1'b0, 10'h000);

    // Same index, different tag: invalidate misses, 110 stays M
    install(3'b110, 3'b011, 2'b10);
    snoop("inv_miss", 2'b00, 2'b10, 3'b010, 1'b0, 1'b0, 10'h000);
    snoop("rd_110", 2'b00, 2'b11, 3'b110, 1'b1, 1'b1, 10'h073);
    // Unknown probe kind: ignored, line 110 remains S
    snoop("kind_ign", 2'b10, 2'b11, 3'b110, 1'b0, 1'b0, 10'h000);
    snoop("wr_110", 2'b01, 2'b11, 3'b110, 1'b1, 1'b0, 10'h000);

    // Memory-data message: shared reported, no state change
    install(3'b001, 3'b111, 2'b10);
    snoop("data_msg", 2'b00, 2'b00, 3'b001, 1'b1, 1'b0, 10'h000);
    snoop("inv_m", 2'b00, 2'b10, 3'b001, 1'b1, 1'b1, 10'h04F);
    snoop("inv_gone", 2'b00, 2'b11, 3'b001, 1'b0, 1'b0, 10'h000);

    // Local request colliding with snoop edge
    install(3'b011, 3'b010, 2'b01);
    bus       = {2'b00, 2'b11, 3'b011, 3'b000};
    snoop_en  = 1'b1;
    loc_addr  = 3'b111;
    loc_data  = 3'b100;
    loc_state = 2'b10;
    loc_valid = 1'b1;
    #1;
    chk("coll_rdy_edge", {15'd0, loc_ready}, 16'd0);
    tick();
    chk("coll_rdy_lookup", {15'd0, loc_ready}, 16'd0);
    tick();
    tick();
    chk("coll_shared", {15'd0, shared}, 16'd1);
    chk("coll_wb", {15'd0, wb_valid}, 16'd0);
    tick();
    chk("coll_done", {15'd0, snoop_done}, 16'd1);
    tick();
    chk("coll_rdy_hold", {15'd0, loc_ready}, 16'd0);
    snoop_en = 1'b0;
    #1;
    chk("coll_rdy_fall", {15'd0, loc_ready}, 16'd0);
    tick();
    chk("coll_rdy_idle", {15'd0, loc_ready}, 16'd1);
    tick();
    loc_valid = 1'b0;
    snoop("coll_new", 2'b00, 2'b11, 3'b111, 1'b1, 1'b1, 10'h07C);

    // snoop_en dropped right after the edge: snoop still completes
    install(3'b100, 3'b001, 2'b10);
    bus      = {2'b00, 2'b10, 3'b100, 3'b000};
    snoop_en = 1'b1;
    tick();
    snoop_en = 1'b0;
    tick();
    tick();
    chk("early_wb", {15'd0, wb_valid}, 16'd1);
    chk("early_bus", {6'd0, bus_out}, 16'h061);
    tick();
    chk("early_done", {15'd0, snoop_done}, 16'd1);
    tick();
    chk("early_clr", {5'd0, wb_valid, bus_out}, 16'd0);
    chk("early_idle", {15'd0, loc_ready}, 16'd1);
    snoop("early_gone", 2'b00, 2'b11, 3'b100, 1'b0, 1'b0, 10'h000);

    // Reset in RESPOND with an M line
    install(3'b101, 3'b110, 2'b10);
    bus      = {2'b00, 2'b11, 3'b101, 3'b000};
    snoop_en = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    #1;
    chk("midrst_outs", {12'd0, shared, wb_valid, snoop_done, loc_ready}, 16'd0);
    chk("midrst_bus", {6'd0, bus_out}, 16'd0);
    snoop_en = 1'b0;
    #2;
    clear = 1'b1;
    tick();
    chk("midrst_ready", {15'd0, loc_ready}, 16'd1);
    snoop("rst_l0", 2'b00, 2'b11, 3'b000, 1'b0, 1'b0, 10'h000);
    snoop("rst_l1", 2'b00, 2'b11, 3'b101, 1'b0, 1'b0, 10'h000);
    snoop("rst_l2", 2'b00, 2'b11, 3'b010, 1'b0, 1'b0, 10'h000);
    snoop("rst_l3", 2'b00, 2'b11, 3'b011, 1'b0, 1'b0, 10'h000);

`ifdef SNOOP_STATS_EN
    chk("stat_zero", {hit_cnt, wb_cnt}, 16'h0000);
    for (int i = 0; i < 300; i++) begin
      install(3'b010, 3'b101, 2'b10);
      snoop("stat", 2'b00, 2'b11, 3'b010, 1'b1, 1'b1, 10'h055);
      if (i == 0) chk("stat_first", {hit_cnt, wb_cnt}, 16'h0101);
    end
    chk("stat_hit_sat", {8'd0, hit_cnt}, 16'd255);
    chk("stat_wb_sat", {8'd0, wb_cnt}, 16'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
# snoop_responder

Cache-side end of the snooping bus protocol: one instance per processor, listening to the shared 10-bit bus while the central sequencer has this CPU in listen mode. Holds a 4-line direct-mapped MSI tag/state/data store, answers probes with a shared indication, supplies the abort-memory-access write-back message when it owns a modified copy, and downgrades or invalidates its lines. The local processor side installs and updates lines through a simple ready/valid port.

## Interface
- LINES, 4, number of cache lines (power of two; index = addr[1:0] at default)
- ADDR_W, 3, block address (tag field) width
- DATA_W, 3, block data width
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-low reset (0 = reset)
- snoop_en  in  1  level listen window from sequencer; rising edge starts one snoop
- bus  in  10  shared bus: [9:8] request kind, [7:6] message type, [5:3] addr, [2:0] data
- shared  out  1  addressed block present (S or M) in this cache
- bus_out  out  10  message offered to sequencer for the bus
- wb_valid  out  1  bus_out holds a valid write-back message
- loc_valid  in  1  local install/update request
- loc_ready  out  1  local request accepted this cycle when loc_valid & loc_ready
- loc_addr  in  3  block address of local request
- loc_data  in  3  data of local request
- loc_state  in  2  new MSI state (I=00, S=01, M=10)
- snoop_done  out  1  one-cycle pulse when a snoop finishes its state update

## Operation
- Message types [7:6]: 00 memory data, 01 write-back/abort, 10 invalidate, 11 probe. Probe kind [9:8]: 00 read miss, 01 write miss; other kinds ignored (no state change, shared=0, snoop_done still pulses).
- FSM IDLE -> LOOKUP -> RESPOND -> UPDATE -> HOLD -> IDLE.
- IDLE: on snoop_en 0->1 (edge detected against registered copy) latch bus into snoop_msg, go LOOKUP. Otherwise serve local port.
- LOOKUP: read line at addr index; hit = state!=I and stored upper tag == addr upper bits.
- RESPOND: shared <= hit. If hit & state M & (probe or invalidate): bus_out <= {2'b00, 2'b01, addr, line data}, wb_valid <= 1. Else bus_out <= 0, wb_valid <= 0.
- UPDATE: read-miss probe: M->S, S->S. Write-miss probe or invalidate: M->I, S->I. Miss or messages 00/01: no change. Pulse snoop_done.
- HOLD: keep shared, bus_out, wb_valid until snoop_en low; then clear wb_valid and bus_out, keep shared until next snoop, go IDLE.
- Local port: loc_ready = 1 only in IDLE with no snoop_en rising edge this cycle. Accepted request writes tag, data, state at addr index (overwrites any existing line; eviction write-back is the processor's job).

## Timing
- Reset: all lines I, data and tags 0, shared=0, bus_out=0, wb_valid=0, snoop_done=0, loc_ready=0 during reset, FSM IDLE, counters 0.
- snoop_en rises seen at edge T -> LOOKUP at T+1 -> shared/bus_out/wb_valid valid after edge T+2 -> snoop_done high cycle T+3. Sequencer samples shared at T+3 or later.
- snoop_en dropping before RESPOND: snoop completes normally (state update still applied), outputs cleared on reaching HOLD.
- snoop_en high continuously: exactly one snoop per rising edge.
- Simultaneous snoop edge and loc_valid: snoop wins, loc_ready=0, local request waits.
- Local write to the line under snoop cannot occur (loc_ready=0 outside IDLE).
- clear asserted mid-snoop: immediate return to reset values, snoop discarded.

## Configuration
- SNOOP_STATS_EN defined: adds outputs hit_cnt[7:0] and wb_cnt[7:0], incremented in UPDATE on hit and on wb_valid respectively, saturating at 255, reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package snoop_pkg: MSI state encodings, message type codes (MSG_DATA, MSG_WB, MSG_INV, MSG_PROBE), probe kinds, bus field bit positions, FSM state type.
- Sub-module snoop_tag_array: LINES-entry register file (tag, data, state), one read port, one write port, async active-low clear to I.

## Test plan
- Install addr 010 data 101 state M; probe read-miss addr 010 -> shared=1, bus_out=10'b00_01_010_101, wb_valid=1, line becomes S.
- Line 010 in S; probe write-miss addr 010 -> shared=1, wb_valid=0, line becomes I; repeat probe -> shared=0.
- Line 110 M; invalidate addr 010 (same index, different tag) -> shared=0, wb_valid=0, line 110 stays M.
- loc_valid asserted same cycle as snoop_en rise -> loc_ready=0, snoop finishes, local write accepted first IDLE cycle after snoop_en falls.
- clear driven 0 during RESPOND with line M -> all outputs 0, all lines I after release.
- With SNOOP_STATS_EN: 300 hitting M-probes alternating install/read-miss -> hit_cnt=255, wb_cnt=255.
